// File: rtl/id_inst_buffer.sv
// Fetch-to-decode instruction buffer: DEPTH-entry first-word-fall-through queue
// carrying the fetch bus plus instruction word, cleared in one cycle on redirect/flush.
module id_inst_buffer #(
  parameter int DATA_WD      = 65,
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     br_taken,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WD-1:0]       in_bus,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WD-1:0]       out_bus,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WD + 32;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          clear;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Status flags come from the occupancy register only, so no input reaches an output.
  assign clear       = flush | br_taken;
  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AFULL_TH);
  assign count       = count_q;

  assign push = in_valid & in_ready & ~clear;
  assign pop  = out_valid & out_ready & ~clear;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (clear) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; stale entries are hidden by the out_valid mask below.
  always_ff @(posedge clk) begin
    if (push && resetn) mem_q[wp_q] <= {in_bus, in_inst};
  end

  assign head     = mem_q[rp_q];
  assign out_inst = head[31:0] & {32{out_valid}};
  assign out_bus  = head[EW-1:32] & {DATA_WD{out_valid}};

endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_id_inst_buffer;

  localparam int DATA_WD      = 65;
  localparam int DEPTH        = 4;
  localparam int AFULL_MARGIN = 1;
  localparam int CW           = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               resetn, flush, br_taken, in_valid, in_ready;
  logic               out_valid, out_ready, almost_full;
  logic [DATA_WD-1:0] in_bus, out_bus;
  logic [31:0]        in_inst, out_inst;
  logic [CW-1:0]      count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [DATA_WD-1:0] bus;
    logic [31:0]        inst;
  } entry_t;

  entry_t model_q[$];

  always #5 clk = ~clk;

  id_inst_buffer #(
    .DATA_WD(DATA_WD), .DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .br_taken(br_taken),
    .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus), .out_inst(out_inst),
    .count(count), .almost_full(almost_full)
  );

  function automatic logic [DATA_WD-1:0] bus_for(input logic [31:0] pc);
    return {1'($urandom), 32'($urandom), pc};
  endfunction

  function automatic logic [CW-1:0] m_count();
    return CW'(model_q.size());
  endfunction

  function automatic logic [31:0] m_inst();
    return (model_q.size() != 0) ? model_q[0].inst : 32'h0;
  endfunction

  function automatic logic [DATA_WD-1:0] m_bus();
    return (model_q.size() != 0) ? model_q[0].bus : '0;
  endfunction

  // Applies one cycle of inputs, advances the reference model at the edge, then waits 1ns.
  task automatic drive(input logic rn, input logic v, input logic [31:0] inst,
                       input logic [DATA_WD-1:0] bus, input logic ordy,
                       input logic fl, input logic br);
    bit do_push, do_pop;
    resetn = rn; in_valid = v; in_inst = inst; in_bus = bus;
    out_ready = ordy; flush = fl; br_taken = br;
    @(posedge clk);
    if (!rn || fl || br) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && ordy;
      do_push = v && (model_q.size() != DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({bus, inst});
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 32'hDEAD0001, bus_for(32'h1C000000), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hDEAD0002, bus_for(32'h1C000004), 1'b0, 1'b0, 1'b0);
    n_tests++; if (count !== 0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    n_tests++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    n_tests++; if (out_bus !== '0) begin n_fail++; $display("FAIL reset_out_bus got=%h exp=0", out_bus); end
    drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (count !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release count=%0d out_valid=%b exp=0/0", count, out_valid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill();
    logic [31:0] inst;
    for (int i = 1; i <= 4; i++) begin
      inst = 32'h1C000000 + 32'(i);
      drive(1'b1, 1'b1, inst, bus_for(32'h1C010000 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
      n_tests++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      n_tests++; if (almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, (i >= 3)); end
      n_tests++; if (in_ready !== (i != 4)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i != 4)); end
      n_tests++; if (out_inst !== 32'h1C000001) begin n_fail++; $display("FAIL fill_head[%0d] got=%h exp=1c000001", i, out_inst); end
    end
    drive(1'b1, 1'b1, 32'h1C000005, bus_for(32'h1C010014), 1'b0, 1'b0, 1'b0);
    n_tests++; if (count !== 4) begin n_fail++; $display("FAIL fill_drop_count got=%0d exp=4", count); end
    n_tests++; if (out_inst !== 32'h1C000001) begin n_fail++; $display("FAIL fill_drop_head got=%h exp=1c000001", out_inst); end
    n_tests++; if (out_bus !== m_bus()) begin n_fail++; $display("FAIL fill_head_bus got=%h exp=%h", out_bus, m_bus()); end
    $display("[TB] test_fill done");
  endtask

  task automatic test_full_simultaneous();
    drive(1'b1, 1'b1, 32'h1C000006, bus_for(32'h1C010018), 1'b1, 1'b0, 1'b0);
    n_tests++; if (count !== 3) begin n_fail++; $display("FAIL fullsim_count got=%0d exp=3", count); end
    n_tests++; if (out_inst !== 32'h1C000002) begin n_fail++; $display("FAIL fullsim_head got=%h exp=1c000002", out_inst); end
    drive(1'b1, 1'b1, 32'h1C000007, bus_for(32'h1C01001C), 1'b1, 1'b0, 1'b0);
    n_tests++; if (count !== 3) begin n_fail++; $display("FAIL fullsim_pp_count got=%0d exp=3", count); end
    n_tests++; if (out_inst !== 32'h1C000003) begin n_fail++; $display("FAIL fullsim_pp_head got=%h exp=1c000003", out_inst); end
    $display("[TB] test_full_simultaneous done");
  endtask

  task automatic test_wrap();
    logic [31:0]        sent_inst [10];
    logic [31:0]        sent_pc   [10];
    logic [DATA_WD-1:0] sent_bus  [10];
    int  ns = 0;
    int  nr = 0;
    bit  ordy, pushing, accepted;
    drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sent_pc[i]   = 32'h1C002000 + 32'(4 * i);
      sent_inst[i] = $urandom | 32'h1;
      sent_bus[i]  = bus_for(sent_pc[i]);
    end
    for (int cyc = 0; cyc < 60 && nr < 10; cyc++) begin
      ordy = (cyc % 2) == 0;
      if (out_valid && ordy) begin
        n_tests++; if (out_inst !== sent_inst[nr]) begin n_fail++; $display("FAIL wrap_inst[%0d] got=%h exp=%h", nr, out_inst, sent_inst[nr]); end
        n_tests++; if (out_bus[31:0] !== sent_pc[nr]) begin n_fail++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", nr, out_bus[31:0], sent_pc[nr]); end
        n_tests++; if (out_bus !== sent_bus[nr]) begin n_fail++; $display("FAIL wrap_bus[%0d] got=%h exp=%h", nr, out_bus, sent_bus[nr]); end
        nr++;
      end
      pushing  = ns < 10;
      accepted = pushing && in_ready;
      drive(1'b1, pushing, sent_inst[pushing ? ns : 0], sent_bus[pushing ? ns : 0], ordy, 1'b0, 1'b0);
      if (accepted) ns++;
      n_tests++; if (count !== m_count()) begin n_fail++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, m_count()); end
    end
    n_tests++; if (nr != 10) begin n_fail++; $display("FAIL wrap_budget received=%0d exp=10", nr); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
        drive(1'b1, 1'b1, 32'h1C003000 + 32'(i), bus_for(32'h1C003000 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
      n_tests++; if (count !== 3) begin n_fail++; $display("FAIL flush_pre_count[%0d] got=%0d exp=3", pass, count); end
      drive(1'b1, 1'b1, 32'h1C0030FF, bus_for(32'h1C0030FC), 1'b1, pass == 1, pass == 0);
      n_tests++; if (count !== 0) begin n_fail++; $display("FAIL flush_count[%0d] got=%0d exp=0", pass, count); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid[%0d] got=%b exp=0", pass, out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready[%0d] got=%b exp=1", pass, in_ready); end
      n_tests++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL flush_out_inst[%0d] got=%h exp=0", pass, out_inst); end
      drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
      n_tests++; if (count !== 0) begin n_fail++; $display("FAIL flush_absent[%0d] got=%0d exp=0", pass, count); end
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'h1C004000, bus_for(32'h1C004000), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h1C004001, bus_for(32'h1C004004), 1'b0, 1'b0, 1'b0);
    n_tests++; if (count !== 2) begin n_fail++; $display("FAIL rstmid_pre_count got=%0d exp=2", count); end
    drive(1'b0, 1'b1, 32'h1C004002, bus_for(32'h1C004008), 1'b1, 1'b0, 1'b0);
    n_tests++; if (count !== 0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    drive(1'b1, 1'b1, 32'h1C004003, bus_for(32'h1C00400C), 1'b0, 1'b0, 1'b0);
    n_tests++; if (count !== 1) begin n_fail++; $display("FAIL rstmid_resume_count got=%0d exp=1", count); end
    n_tests++; if (out_inst !== 32'h1C004003) begin n_fail++; $display("FAIL rstmid_resume_head got=%h exp=1c004003", out_inst); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    logic rn, v, ordy, fl, br;
    logic [31:0] inst, pc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rn   = $urandom_range(0, 49) != 0;
      fl   = $urandom_range(0, 24) == 0;
      br   = $urandom_range(0, 24) == 0;
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 2) != 0;
      inst = $urandom;
      pc   = $urandom & 32'hFFFF_FFFC;
      drive(rn, v, inst, bus_for(pc), ordy, fl, br);
      n_tests++;
      if (count !== m_count() || out_valid !== (m_count() != 0) ||
          in_ready !== (m_count() != CW'(DEPTH)) ||
          almost_full !== (m_count() >= CW'(DEPTH - AFULL_MARGIN)) ||
          out_inst !== m_inst() || out_bus !== m_bus()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got cnt=%0d v=%b r=%b af=%b inst=%h bus=%h exp cnt=%0d inst=%h bus=%h",
                 cyc, count, out_valid, in_ready, almost_full, out_inst, out_bus, m_count(), m_inst(), m_bus());
      end
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simultaneous();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_inst_buffer.md
# id_inst_buffer

Parametrised instruction buffer between the fetch stage and the decode stage. It replaces the single-entry instruction hold register with a DEPTH-entry first-word-fall-through queue. The queue holds the fetch bus (pc, exception flags, interrupt vector) together with the instruction word. Fetch can run ahead of a stalled decode stage. Branch redirects and exception flushes clear all buffered entries in one cycle.

## Interface
Parameters:
- DATA_WD, 65: width of the fetch-to-decode bus carried with each instruction.
- DEPTH, 4: number of entries. Must be a power of two, minimum 2.
- AFULL_MARGIN, 1: almost_full asserts when count >= DEPTH - AFULL_MARGIN. Range 0 to DEPTH-1.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- resetn, input, 1: synchronous, active-low reset.
- flush, input, 1: exception/ertn flush; empties the buffer.
- br_taken, input, 1: branch redirect from EX; empties the buffer, same effect as flush.
- in_valid, input, 1: fetch presents a valid instruction this cycle.
- in_ready, output, 1: buffer can accept an entry. Equals (count != DEPTH), decoded from registers only.
- in_bus, input, DATA_WD: fetch-to-decode bus for the pushed entry.
- in_inst, input, 32: instruction word for the pushed entry.
- out_valid, output, 1: head entry valid. Equals (count != 0).
- out_ready, input, 1: decode accepts the head this cycle. Driven as !stall[1].
- out_bus, output, DATA_WD: head bus; all zeros when out_valid=0.
- out_inst, output, 32: head instruction; 32'b0 when out_valid=0, which decodes as a nop.
- count, output, $clog2(DEPTH)+1: current occupancy.
- almost_full, output, 1: occupancy at or above the threshold; fetch uses it to stop issuing requests.

## Operation
- Storage: DEPTH x (DATA_WD+32) register array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, and a count register.
- push = in_valid & in_ready & !flush & !br_taken.
- pop = out_valid & out_ready & !flush & !br_taken.
- Push writes mem[wp] and increments wp.
- Pop increments rp.
- Pointers wrap naturally modulo DEPTH, from DEPTH-1 to 0.
- count' = count + push - pop.
  - Push and pop in the same cycle leave count unchanged. Both pointers still advance.
  - When full, in_ready=0, so push cannot occur; a pop is still accepted.
  - When empty, out_valid=0, so pop cannot occur; a push makes the entry visible on the next cycle. There is no combinational bypass from in_* to out_*.
- Flush priority: resetn low > flush|br_taken > push/pop.
  - On flush or br_taken, wp, rp and count go to 0. Any same-cycle push or pop is discarded.
  - Memory contents are not cleared; they are masked by the valid logic.
- Outputs out_bus and out_inst are mem[rp] ANDed with {out_valid}. A mid-stall decode stage therefore always sees either a real instruction or a zero nop.
- There is no overflow or underflow state. Illegal in_valid while in_ready=0 is ignored; the entry is dropped and fetch must hold it.

## Timing
- Reset (resetn=0 at an edge): wp=rp=0 and count=0. After reset:
  - out_valid=0, in_ready=1, almost_full=0.
  - out_bus=0 and out_inst=0.
- Reset mid-operation discards all entries at that edge, regardless of in_valid, out_ready or flush.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N is on out_* from edge N until it is popped.
- Pop takes effect at the edge. The next entry, or zeros if the queue becomes empty, appears immediately after that edge.
- Flush latency: out_valid=0 and in_ready=1 in the cycle after the flush edge.
- in_ready, out_valid, almost_full and count depend only on registers. There is no combinational path from any input to any output except through resetn at the clock edge.
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH-1.

## Test plan
- Reset: hold resetn=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_inst=0 after release.
- Fill: DEPTH=4, out_ready=0, push inst 0x1C000001..0x1C000004.
  - count goes 1,2,3,4. almost_full asserts at count=3.
  - in_ready=0 at count=4. A fifth push of 0x1C000005 is dropped.
  - out_inst stays 0x1C000001.
- Full simultaneous: at count=4, set out_ready=1 and in_valid=1.
  - The pop is accepted and the push is not; count=3.
  - Next head is 0x1C000002. On the following cycle, push and pop together hold count=3.
- Wrap-around: stream 10 instructions with out_ready toggling 1,0,1,0.
  - Output order equals input order across pointer wrap.
  - out_bus pc field matches each instruction.
- Flush: at count=3, assert br_taken with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0. The pushed entry is absent. Repeat the same check with flush.
- Reset mid-stream: at count=2, pulse resetn=0 for one cycle while pushing -> count=0, out_valid=0. Normal pushes resume on the next cycle.
